// File: rtl/burst_toggle_gen.sv
// burst_toggle_gen: independent per-channel toggle generators running either
// bounded one-shot bursts (with a done pulse) or free-running toggle streams.
module burst_toggle_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      internal_clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH-1:0]         stop,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH-1:0]         mode,
    input  logic [NUM_CH*CNT_W-1:0]   limit,
    output logic [NUM_CH-1:0]         q,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH*CNT_W-1:0]   count
);

    typedef enum logic {IDLE, RUN} state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t             state, state_n;
        logic               q_r, q_n, done_r, done_n, md, md_n;
        logic [CNT_W-1:0]   cnt, cnt_n, lim, lim_n, cnt_inc, lim_in;

        assign lim_in  = limit[i*CNT_W +: CNT_W];
        assign cnt_inc = cnt + CNT_W'(1);

        always_ff @(posedge internal_clk or posedge reset) begin
            if (reset) begin
                state  <= IDLE;
                q_r    <= 1'b0;
                done_r <= 1'b0;
                md     <= 1'b0;
                cnt    <= '0;
                lim    <= '0;
            end else begin
                state  <= state_n;
                q_r    <= q_n;
                done_r <= done_n;
                md     <= md_n;
                cnt    <= cnt_n;
                lim    <= lim_n;
            end
        end

        // stop outranks both the enable and a completing toggle
        always_comb begin
            state_n = state;
            q_n     = q_r;
            done_n  = 1'b0;
            md_n    = md;
            cnt_n   = cnt;
            lim_n   = lim;
            if (state == IDLE) begin
                if (start[i]) begin
                    lim_n = lim_in;
                    md_n  = mode[i];
                    cnt_n = '0;
                    if (lim_in == '0 && !mode[i])
                        done_n = 1'b1;
                    else
                        state_n = RUN;
                end
            end else if (stop[i]) begin
                state_n = IDLE;
            end else if (en[i]) begin
                q_n   = ~q_r;
                cnt_n = cnt_inc;
                if (!md && cnt_inc == lim) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
        end

        assign q[i]                     = q_r;
        assign busy[i]                  = (state == RUN);
        assign done[i]                  = done_r;
        assign count[i*CNT_W +: CNT_W]  = cnt;
    end

endmodule

// File: tb/tb_burst_toggle_gen.sv
// tb_burst_toggle_gen: directed table vectors plus hand-written corner sequences
// for the four-channel burst toggle generator.
module tb_burst_toggle_gen;

    logic        internal_clk, reset;
    logic [3:0]  start, stop, en, mode;
    logic [31:0] limit;
    logic [3:0]  q, busy, done;
    logic [31:0] count;

    int checks = 0;
    int failures = 0;

    burst_toggle_gen #(.NUM_CH(4), .CNT_W(8)) dut (
        .internal_clk(internal_clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .en(en),
        .mode(mode),
        .limit(limit),
        .q(q),
        .busy(busy),
        .done(done),
        .count(count)
    );

    initial internal_clk = 1'b0;
    always #5 internal_clk = ~internal_clk;

    typedef struct {
        logic [3:0]  start, stop, en, mode;
        logic [31:0] limit;
        logic [3:0]  q, busy, done;
        logic [31:0] count;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge internal_clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eq, input logic [3:0] eb,
                           input logic [3:0] ed, input logic [31:0] ec);
        chk({tag, ".q"}, {28'd0, q}, {28'd0, eq});
        chk({tag, ".busy"}, {28'd0, busy}, {28'd0, eb});
        chk({tag, ".done"}, {28'd0, done}, {28'd0, ed});
        chk({tag, ".count"}, count, ec);
    endtask

    vec_t tv[16];

    initial begin
        // one-shot limit 5 on ch0, then limit 4 on ch2 with a 3-cycle pause
        tv[0]  = '{4'b0001, 4'b0, 4'b1111, 4'b0, 32'h0000_0005, 4'b0000, 4'b0001, 4'b0000, 32'h0000_0000};
        tv[1]  = '{4'b0000, 4'b0, 4'b1111, 4'b0, 32'h0000_0005, 4'b0001, 4'b0001, 4'b0000, 32'h0000_0001};
        tv[2]  = '{4'b0000, 4'b0, 4'b1111, 4'b0, 32'h0000_0000, 4'b0000, 4'b0001, 4'b0000, 32'h0000_0002};
        tv[3]  = '{4'b0000, 4'b0, 4'b1111, 4'b0, 32'h0000_0000, 4'b0001, 4'b0001, 4'b0000, 32'h0000_0003};
        tv[4]  = '{4'b0000, 4'b0, 4'b1111, 4'b0, 32'h0000_0000, 4'b0000, 4'b0001, 4'b0000, 32'h0000_0004};
        tv[5]  = '{4'b0000, 4'b0, 4'b1111, 4'b0, 32'h0000_0000, 4'b0001, 4'b0000, 4'b0001, 32'h0000_0005};
        tv[6]  = '{4'b0000, 4'b0, 4'b1111, 4'b0, 32'h0000_0000, 4'b0001, 4'b0000, 4'b0000, 32'h0000_0005};
        tv[7]  = '{4'b0100, 4'b0, 4'b1111, 4'b0, 32'h0004_0000, 4'b0001, 4'b0100, 4'b0000, 32'h0000_0005};
        tv[8]  = '{4'b0000, 4'b0, 4'b1111, 4'b0, 32'h0000_0000, 4'b0101, 4'b0100, 4'b0000, 32'h0001_0005};
        tv[9]  = '{4'b0000, 4'b0, 4'b1111, 4'b0, 32'h0000_0000, 4'b0001, 4'b0100, 4'b0000, 32'h0002_0005};
        tv[10] = '{4'b0000, 4'b0, 4'b1011, 4'b0, 32'h0000_0000, 4'b0001, 4'b0100, 4'b0000, 32'h0002_0005};
        tv[11] = '{4'b0000, 4'b0, 4'b1011, 4'b0, 32'h0000_0000, 4'b0001, 4'b0100, 4'b0000, 32'h0002_0005};
        tv[12] = '{4'b0000, 4'b0, 4'b1011, 4'b0, 32'h0000_0000, 4'b0001, 4'b0100, 4'b0000, 32'h0002_0005};
        tv[13] = '{4'b0000, 4'b0, 4'b1111, 4'b0, 32'h0000_0000, 4'b0101, 4'b0100, 4'b0000, 32'h0003_0005};
        tv[14] = '{4'b0000, 4'b0, 4'b1111, 4'b0, 32'h0000_0000, 4'b0001, 4'b0000, 4'b0100, 32'h0004_0005};
        tv[15] = '{4'b0000, 4'b0, 4'b1111, 4'b0, 32'h0000_0000, 4'b0001, 4'b0000, 4'b0000, 32'h0004_0005};

        start = '0; stop = '0; en = '0; mode = '0; limit = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1 chk_all("reset", 4'b0, 4'b0, 4'b0, 32'h0);
        #1 reset = 1'b0;

        for (int r = 0; r < 16; r++) begin
            start = tv[r].start; stop = tv[r].stop; en = tv[r].en;
            mode = tv[r].mode; limit = tv[r].limit;
            tick();
            chk_all($sformatf("vec%0d", r), tv[r].q, tv[r].busy, tv[r].done, tv[r].count);
        end

        // free-run on ch1: count wraps at enabled edge 256, then stop freezes it
        start = 4'b0010; mode = 4'b0010; limit = 32'h0000_0300; en = 4'b0010;
        tick();
        chk("fr.busy", {28'd0, busy}, 32'h2);
        start = '0; mode = '0;
        for (int k = 1; k <= 261; k++) begin
            tick();
            chk("fr.nodone", {31'd0, done[1]}, 32'd0);
            if (k == 255) chk("fr.cnt255", {24'd0, count[15:8]}, 32'd255);
            if (k == 256) chk("fr.wrap", {24'd0, count[15:8]}, 32'd0);
        end
        chk("fr.cnt", {24'd0, count[15:8]}, 32'd5);
        chk("fr.q", {31'd0, q[1]}, 32'd1);
        stop = 4'b0010;
        tick();
        chk("fr.stop.busy", {28'd0, busy}, 32'h0);
        chk("fr.stop.cnt", {24'd0, count[15:8]}, 32'd5);
        chk("fr.stop.q", {31'd0, q[1]}, 32'd1);
        chk("fr.stop.done", {28'd0, done}, 32'h0);
        stop = '0;
        tick();
        chk("fr.frozen.cnt", {24'd0, count[15:8]}, 32'd5);
        chk("fr.frozen.q", {31'd0, q[1]}, 32'd1);

        // ch3 burst aborted by an asynchronous reset between edges
        start = 4'b1000; limit = 32'h0A00_0000; en = 4'b1111;
        tick();
        start = '0;
        tick(); tick(); tick();
        chk("ar.pre.cnt", {24'd0, count[31:24]}, 32'd3);
        chk("ar.pre.q", {31'd0, q[3]}, 32'd1);
        #2 reset = 1'b1;
        #1 chk_all("ar.async", 4'b0, 4'b0, 4'b0, 32'h0);
        tick();
        chk_all("ar.held", 4'b0, 4'b0, 4'b0, 32'h0);
        reset = 1'b0;
        start = 4'b1000; limit = 32'h0200_0000;
        tick();
        start = '0;
        chk("ar.busy", {28'd0, busy}, 32'h8);
        tick();
        chk_all("ar.t1", 4'b1000, 4'b1000, 4'b0000, 32'h0100_0000);
        tick();
        chk_all("ar.t2", 4'b0000, 4'b0000, 4'b1000, 32'h0200_0000);
        tick();
        chk("ar.done.clr", {28'd0, done}, 32'h0);

        // zero limit gives an immediate done; restart in the done cycle
        start = 4'b0001; limit = 32'h0;
        tick();
        chk_all("z.done", 4'b0, 4'b0, 4'b0001, 32'h0200_0000);
        limit = 32'h0000_0003;
        tick();
        start = '0;
        chk_all("z.restart", 4'b0, 4'b0001, 4'b0, 32'h0200_0000);
        tick();
        chk_all("z.t1", 4'b0001, 4'b0001, 4'b0, 32'h0200_0001);
        tick();
        chk_all("z.t2", 4'b0000, 4'b0001, 4'b0, 32'h0200_0002);
        tick();
        chk_all("z.t3", 4'b0001, 4'b0000, 4'b0001, 32'h0200_0003);
        tick();

        // all channels together; re-pulsed start with different limits is ignored
        start = 4'b1111; limit = 32'h0403_0201;
        tick();
        chk_all("all.start", 4'b0001, 4'b1111, 4'b0000, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            start = 4'b1111 << (k - 1);
            limit = 32'h0909_0909;
            tick();
            chk($sformatf("all.done%0d", k), {28'd0, done}, 32'd1 << (k - 1));
            chk($sformatf("all.busy%0d", k), {28'd0, busy}, {28'd0, 4'b1111 << k});
        end
        start = '0;
        tick();
        chk_all("all.end", 4'b0100, 4'b0000, 4'b0000, 32'h0403_0201);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded bound");
        $fatal(1);
    end

endmodule
